// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with registered operands/result.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_y,
  output logic                      resp_co,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_y,
  input  logic                      alu_co,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_vld;
  logic [IDX_W-1:0] search_base;
  logic             resp_done;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  assign search_base = rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (resp_done) begin
      rr_ptr <= wrap_idx(int'(winner) + 1);
    end
  end
`endif

  // First valid requester at or after search_base, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(int'(search_base) + i);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign resp_done = (state == RESP) && resp_ready[winner];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC;
      EXEC:    state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (resp_ready[winner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accept stage: operands and winner captured on the grant edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (state == IDLE && grant_vld) begin
      winner <= grant_idx;
      alu_a  <= req_a[grant_idx*DATA_W +: DATA_W];
      alu_b  <= req_b[grant_idx*DATA_W +: DATA_W];
      alu_op <= req_op[grant_idx*OP_W +: OP_W];
    end
  end

  // Capture stage: ALU result registered once inputs have settled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_y  <= '0;
      resp_co <= 1'b0;
    end else if (state == CAPT) begin
      resp_y  <= alu_y;
      resp_co <= alu_co;
    end
  end

  // Gated by reset so no handshake is offered while reset is held.
  assign req_ready  = (state == IDLE && grant_vld && !reset) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << winner) : '0;
  assign busy       = (state != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (operands a/b, 4-bit opcode, result y plus carry-out co) between NUM_REQ requesters.
- Arbitration is round-robin.
- Operands, opcode and result are registered, and each operation is sequenced through a small FSM.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- Sits between the requesting blocks and the ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand and result width.
- OP_W, 4, opcode width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero).
- req_a  in  NUM_REQ*DATA_W  packed operand A; requester i is at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand B.
- req_op  in  NUM_REQ*OP_W  packed opcode.
- resp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero).
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_y  out  DATA_W  result, shared by all requesters.
- resp_co  out  1  carry-out, shared by all requesters.
- alu_a  out  DATA_W  registered operand A to the ALU.
- alu_b  out  DATA_W  registered operand B to the ALU.
- alu_op  out  OP_W  registered opcode to the ALU.
- alu_y  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_co  in  1  ALU carry-out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_ptr=0, winner=0.
  - alu_a, alu_b, alu_op, resp_y, resp_co = 0.
  - req_ready, resp_valid, busy = 0.
  - Reset mid-operation abandons the operation; no response is produced for it.
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - If any req_valid is high, select the winner by round-robin: the first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[winner] is combinationally high in this cycle only; the handshake completes in this cycle.
  - On the clock edge: latch the winner's a/b/op into alu_a/alu_b/alu_op, store winner, go to EXEC.
  - If no req_valid is high, stay in IDLE and assert no req_ready.
- EXEC: one cycle for the ALU inputs to settle; go to CAPT.
- CAPT: register alu_y into resp_y and alu_co into resp_co; go to RESP.
- RESP:
  - resp_valid[winner]=1, with resp_y/resp_co held stable.
  - Remain in RESP until resp_ready[winner]=1.
  - On that edge: rr_ptr = (winner+1) mod NUM_REQ, go to IDLE.
  - resp_ready on non-winner indices is ignored.
- Timing and throughput:
  - Latency from the accept edge to the first resp_valid cycle is 3 clocks.
  - Best-case throughput is one operation per 4 clocks.
  - No new request is accepted while busy=1.
- Fairness: a requester that holds req_valid high is served within NUM_REQ grants.
- Requester obligations:
  - A requester may drop req_valid before it is granted.
  - Operands must be stable only during the accept cycle.
- Simultaneous requests: exactly one grant per IDLE cycle; req_ready is never multi-hot.
- Opcode handling: alu_op is passed through unchanged. Opcode decode and illegal-op handling belong to the ALU.
- Hold behaviour: alu_a/alu_b/alu_op keep their last values outside EXEC/CAPT. resp_y/resp_co keep their last captured values after RESP.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- When defined:
  - Arbitration is fixed-priority, lowest index wins.
  - rr_ptr is not implemented.
  - Starvation of high indices is permitted.
- When undefined: round-robin as specified above (the default).

Test Plan:
- Single request: after reset, req_valid[2]=1 with a=0x0F, b=0x01 and the add opcode.
  - req_ready[2] is high in the first IDLE cycle.
  - resp_valid[2] rises 3 clocks after accept, with resp_y=0x10 and resp_co=0.
- Carry-out: a=0xFF, b=0x01, add.
  - resp_y=0x00, resp_co=1.
- All requesters valid continuously from reset (round-robin build):
  - Grant order is 0,1,2,3,0.
  - Each response is returned only to its granted index.
- All requesters valid continuously with ALU_ARB_FIXED_PRIO_EN defined:
  - Requester 0 is granted every time.
- Response back-pressure: hold resp_ready[1]=0 for 5 cycles.
  - resp_valid[1], resp_y and resp_co stay stable.
  - No req_ready is asserted until the response is accepted.
- Reset mid-op: assert reset while in CAPT.
  - All outputs are 0 immediately (asynchronous).
  - No resp_valid after reset is released.
  - The next grant goes to index 0.
